// File: rtl/edge_event_pkg.sv
// Shared types for the edge event unit: edge-mode encoding and FSM states.
// Optional input synchronizer is enabled with EDGE_EVENT_SYNC_EN.
package edge_event_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF = 2'b00,
    EDGE_POS = 2'b01,
    EDGE_NEG = 2'b10,
    EDGE_ANY = 2'b11
  } mode_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/edge_event_detect.sv
// Samples the monitored signal and flags edges of the selected kind.
// EDGE_EVENT_SYNC_EN inserts a 2-flop synchronizer ahead of the sampler.
module edge_event_detect
  import edge_event_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       x_i,
  input  logic [1:0] mode_i,
  output logic       edge_o
);

  logic x_s;
  logic x_q;
  logic seen_q;
  logic rise;
  logic fall;

`ifdef EDGE_EVENT_SYNC_EN
  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= x_i;
      s2_q <= s1_q;
    end
  end

  assign x_s = s2_q;
`else
  assign x_s = x_i;
`endif

  // No compare until one real sample has been taken after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      x_q    <= x_s;
      seen_q <= 1'b1;
    end
  end

  assign rise = seen_q & ~x_q & x_s;
  assign fall = seen_q & x_q & ~x_s;

  always_comb begin
    edge_o = 1'b0;
    case (mode_t'(mode_i))
      EDGE_POS: edge_o = rise;
      EDGE_NEG: edge_o = fall;
      EDGE_ANY: edge_o = rise | fall;
      default:  edge_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/edge_event_unit.sv
// Counts qualified edges after an arm request and signals completion.
// EDGE_EVENT_SYNC_EN (see edge_event_detect) adds 2 cycles of edge latency.
module edge_event_unit
  import edge_event_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_i,
  input  logic             iff_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] repeat_i,
  input  logic             arm_i,
  output logic             busy_o,
  output logic             evt_o,
  output logic [CNT_W-1:0] count_o,
  output logic             done_valid_o,
  input  logic             done_ready_i
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             evt_q;
  logic             evt_d;
  logic             edge_det;
  logic             qual;

  edge_event_detect u_detect (
    .clk    (clk),
    .rst    (rst),
    .x_i    (x_i),
    .mode_i (mode_i),
    .edge_o (edge_det)
  );

  assign qual = edge_det & iff_i & (state_q == ST_ARMED);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    evt_d   = qual;
    unique case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          cnt_d   = '0;
          rem_d   = repeat_i;
          state_d = (repeat_i == '0) ? ST_DONE : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (qual) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
          end
          if (rem_q <= 1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (done_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_valid_o = (state_q == ST_DONE);
  assign evt_o        = evt_q;
  assign count_o      = cnt_q;

endmodule

// File: doc/edge_event_unit.md
EDGE_EVENT_UNIT -- requirements
Module: edge_event_unit

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of repeat target and event count.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: x_i  input  1  monitored signal.
REQ-005 SHALL have port: iff_i  input  1  event qualifier; an edge counts only while high.
REQ-006 SHALL have port: mode_i  input  2  edge kind: 00 off, 01 posedge, 10 negedge, 11 any edge.
REQ-007 SHALL have port: repeat_i  input  CNT_W  number of qualified edges to wait for.
REQ-008 SHALL have port: arm_i  input  1  start request, sampled in IDLE only.
REQ-009 SHALL have port: busy_o  output  1  high in ARMED or DONE.
REQ-010 SHALL have port: evt_o  output  1  one-cycle pulse per qualified edge.
REQ-011 SHALL have port: count_o  output  CNT_W  qualified edges seen since last arm.
REQ-012 SHALL have port: done_valid_o  output  1  completion valid.
REQ-013 SHALL have port: done_ready_i  input  1  completion accepted.

Function
REQ-014 SHALL register x_i into x_q every cycle; edge = (x_q==0 & x==1) for posedge, (x_q==1 & x==0) for negedge, either for mode 11, none for mode 00.
REQ-015 SHALL define qualified edge = edge & iff_i & state==ARMED, evaluated on current-cycle inputs.
REQ-016 SHALL use FSM states IDLE, ARMED, DONE.
REQ-017 IDLE: arm_i=1 with repeat_i!=0 -> ARMED, remaining<=repeat_i, count_o<=0; arm_i=1 with repeat_i==0 -> DONE directly, count_o<=0.
REQ-018 ARMED: each qualified edge SHALL decrement remaining and increment count_o; when remaining==1 and qualified edge -> DONE.
REQ-019 SHALL assert evt_o exactly one cycle after the cycle in which the qualified edge was sampled (registered, latency 1).
REQ-020 DONE: done_valid_o=1 and held stable until done_valid_o & done_ready_i, then -> IDLE next cycle.
REQ-021 SHALL ignore arm_i outside IDLE; mode_i, iff_i changes take effect immediately; repeat_i sampled only on arm.
REQ-022 count_o SHALL saturate at all-ones (no wrap); remaining SHALL never underflow.
REQ-023 done_ready_i asserted before done_valid_o SHALL have no effect.
REQ-024 First cycle after reset SHALL NOT report an edge (x_q reset equals 0, edge compare blocked until one sample taken).

Reset
REQ-025 On rst=1 (async): state=IDLE, x_q=0, remaining=0, count_o=0, evt_o=0, done_valid_o=0, busy_o=0.
REQ-026 Reset asserted mid-ARMED or mid-DONE SHALL abandon the operation without a done handshake.

Configuration
REQ-027 Macro EDGE_EVENT_SYNC_EN defined: x_i SHALL pass through a 2-flop synchronizer (reset 0) before x_q, adding 2 cycles edge latency (evt_o at +3).
REQ-028 Macro undefined: no synchronizer; evt_o latency per REQ-019.

Structure
REQ-029 Package edge_event_pkg SHALL hold the mode typedef (EDGE_OFF, EDGE_POS, EDGE_NEG, EDGE_ANY) and state typedef.
REQ-030 Sub-module edge_event_detect SHALL implement x_q register plus edge compare per REQ-014; FSM and counters stay in edge_event_unit.

Verification
REQ-031 mode=01, repeat=3, iff=1, arm; toggle x 0->1 three times -> evt_o three pulses, count_o=3, done_valid_o after third edge+1 cycle.
REQ-032 mode=10, repeat=2, x rising only -> no evt_o, stays ARMED, count_o=0; then two falls -> DONE.
REQ-033 mode=11, repeat=4, iff=0 on 2nd edge -> that edge uncounted; DONE only after 5 total edges.
REQ-034 arm with repeat=0 -> DONE next cycle, count_o=0; hold done_ready_i=0 10 cycles -> done_valid_o stays 1; ready=1 -> IDLE.
REQ-035 rst pulsed while ARMED with count_o=2 -> all outputs 0 immediately, re-arm works normally.
REQ-036 With EDGE_EVENT_SYNC_EN, mode=01 single rise -> evt_o exactly 3 cycles after x_i change.
